// File: rtl/rx_frame_pingpong_if.sv
// Handshake/bus bundle between the UART RX side, the host reader and rx_frame_pingpong.
// master = producer/host side, slave = frame buffer.
interface rx_frame_pingpong_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] r_data;
    logic              frame_ready;
    logic [ADDR_W-1:0] frame_len;
    logic              frame_ack;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output wr, w_data, address, frame_ack, ovf_clr,
        input  r_data, frame_ready, frame_len, overflow
    );

    modport slave (
        input  wr, w_data, address, frame_ack, ovf_clr,
        output r_data, frame_ready, frame_len, overflow
    );
endinterface

// File: rtl/rx_frame_pingpong.sv
// Ping-pong frame buffer for UART RX words with registered random-access reads.
// Optional partial-frame idle flush is enabled by defining RX_FRAME_TMO_EN.
module rx_frame_pingpong #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 5,
    parameter int ADDR_W  = 3,
    parameter int TMO_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_frame_pingpong_if.slave   bus
);
    typedef enum logic {W_FILL, W_WAIT} wstate_t;
    typedef enum logic {R_EMPTY, R_READY} rstate_t;

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LEN_FULL = ADDR_W'(DEPTH);

    if (DEPTH < 2 || (1 << ADDR_W) <= DEPTH || TMO_CYC < 1) begin : g_bad_param
        $error("rx_frame_pingpong: illegal parameter set");
    end

    logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];

    wstate_t           r_wstate, w_wstate_nx;
    rstate_t           r_rstate, w_rstate_nx;
    logic [ADDR_W-1:0] r_wptr, w_wptr_nx;
    logic              r_wbank, r_rbank;
    logic [ADDR_W-1:0] r_frame_len, w_len_nx;
    logic [ADDR_W-1:0] r_pend_len, w_pend_nx;
    logic              r_ovf;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              w_store, w_swap, w_drop, w_evt, w_tmo;
    logic [ADDR_W-1:0] w_evt_len;
    logic [DATA_W-1:0] w_status;

`ifdef RX_FRAME_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] r_idle;

    assign w_tmo = (r_wstate == W_FILL) && !bus.wr && (r_wptr != '0)
                   && (r_idle == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idle <= '0;
        else if (bus.wr || r_wstate != W_FILL || r_wptr == '0 || w_tmo)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_wstate_nx = r_wstate;
        w_rstate_nx = r_rstate;
        w_wptr_nx   = r_wptr;
        w_len_nx    = r_frame_len;
        w_pend_nx   = r_pend_len;
        w_store     = 1'b0;
        w_swap      = 1'b0;
        w_drop      = 1'b0;
        w_evt       = 1'b0;
        w_evt_len   = LEN_FULL;
        unique case (r_wstate)
            W_FILL: begin
                if (bus.wr) begin
                    w_store = 1'b1;
                    if (r_wptr == LAST) begin
                        w_evt     = 1'b1;
                        w_wptr_nx = '0;
                    end else begin
                        w_wptr_nx = r_wptr + 1'b1;
                    end
                end else if (w_tmo) begin
                    w_evt     = 1'b1;
                    w_evt_len = r_wptr;
                    w_wptr_nx = '0;
                end
                // an ack on the completing edge frees the read bank in time
                if (w_evt) begin
                    if (r_rstate == R_EMPTY || bus.frame_ack) begin
                        w_swap   = 1'b1;
                        w_len_nx = w_evt_len;
                    end else begin
                        w_wstate_nx = W_WAIT;
                        w_pend_nx   = w_evt_len;
                    end
                end
            end
            W_WAIT: begin
                w_drop = bus.wr;
                if (bus.frame_ack) begin
                    w_swap      = 1'b1;
                    w_len_nx    = r_pend_len;
                    w_wstate_nx = W_FILL;
                end
            end
            default: w_wstate_nx = W_FILL;
        endcase
        if (w_swap) begin
            w_rstate_nx = R_READY;
        end else if (r_rstate == R_READY && bus.frame_ack) begin
            w_rstate_nx = R_EMPTY;
            w_len_nx    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate    <= W_FILL;
            r_rstate    <= R_EMPTY;
            r_wptr      <= '0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b1;
            r_frame_len <= '0;
            r_pend_len  <= '0;
            r_ovf       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_wstate    <= w_wstate_nx;
            r_rstate    <= w_rstate_nx;
            r_wptr      <= w_wptr_nx;
            r_frame_len <= w_len_nx;
            r_pend_len  <= w_pend_nx;
            r_rdata     <= w_rdata;
            if (w_swap) begin
                r_wbank <= r_rbank;
                r_rbank <= r_wbank;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            else if (bus.ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store)
            r_mem[r_wbank][r_wptr] <= bus.w_data;
    end

    assign w_status = {{(DATA_W-3){1'b0}}, (r_wstate == W_WAIT),
                       r_ovf, (r_rstate == R_READY)};

    always_comb begin
        w_rdata = '0;
        if (bus.address < LEN_FULL)
            w_rdata = r_mem[r_rbank][bus.address];
        else if (bus.address == LEN_FULL)
            w_rdata = w_status;
    end

    assign bus.r_data      = r_rdata;
    assign bus.frame_ready = (r_rstate == R_READY);
    assign bus.frame_len   = r_frame_len;
    assign bus.overflow    = r_ovf;
endmodule
